// File: rtl/a2d_spi_serf_if.sv
// ============================================================================
// a2d_spi_serf_if : SPI wires between the A2D monarch and the A2D serf model
// Revision: 1.0
// ============================================================================
`default_nettype none

interface a2d_spi_serf_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

`default_nettype wire

// File: rtl/a2d_spi_serf.sv
// ============================================================================
// a2d_spi_serf : SPI responder model of an 8-channel 12-bit A2D converter
// Revision: 1.0
// ============================================================================
`default_nettype none

module a2d_spi_serf #(
  parameter int NUM_CH   = 8,
  parameter int RST_CHNL = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  a2d_spi_serf_if.slave        spi,
  input  logic [12*NUM_CH-1:0] ch_data,
  output logic                 cmd_rdy,
  output logic [2:0]           chnl,
  output logic                 xfer_err
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state;
  logic [2:0]  ss_ff;
  logic [2:0]  sclk_ff;
  logic [1:0]  mosi_ff;
  // Only bits [13:11] of the received command matter, so bit 15 is never stored
  logic [14:0] rx_shft;
  logic [15:0] tx_shft;
  logic [4:0]  bit_cnt;
  logic [15:0] resp;

  logic        ss_fall;
  logic        ss_rise;
  logic        sclk_rise;
  logic        sclk_fall;
  logic [14:0] rx_next;
  logic [4:0]  cnt_next;
  logic [2:0]  sel_ch;
  logic [11:0] ch_arr [8];

  // Unpopulated channels read back as zero
  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < NUM_CH) begin : g_live
      assign ch_arr[i] = ch_data[12*i +: 12];
    end else begin : g_pad
      assign ch_arr[i] = 12'h000;
    end
  end

  // Sync flops reset low so SS_n held low through reset never looks like a fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_ff   <= 3'b000;
      sclk_ff <= 3'b000;
      mosi_ff <= 2'b00;
    end else begin
      ss_ff   <= {ss_ff[1:0], spi.SS_n};
      sclk_ff <= {sclk_ff[1:0], spi.SCLK};
      mosi_ff <= {mosi_ff[0], spi.MOSI};
    end
  end

  assign ss_fall   = ~ss_ff[1] &  ss_ff[2];
  assign ss_rise   =  ss_ff[1] & ~ss_ff[2];
  assign sclk_rise =  sclk_ff[1] & ~sclk_ff[2];
  assign sclk_fall = ~sclk_ff[1] &  sclk_ff[2];

  // Shift results are computed ahead so an ss_rise in the same clk sees them
  always_comb begin
    rx_next  = rx_shft;
    cnt_next = bit_cnt;
    if (sclk_rise) begin
      rx_next = {rx_shft[13:0], mosi_ff[1]};
      if (bit_cnt != 5'd31) begin
        cnt_next = bit_cnt + 5'd1;
      end
    end
  end

  assign sel_ch   = rx_next[13:11];
  assign spi.MISO = (state == SHIFT) & tx_shft[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rx_shft  <= '0;
      tx_shft  <= '0;
      bit_cnt  <= '0;
      resp     <= 16'h0000;
      chnl     <= 3'(RST_CHNL);
      cmd_rdy  <= 1'b0;
      xfer_err <= 1'b0;
    end else begin
      cmd_rdy  <= 1'b0;
      xfer_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            tx_shft <= resp;
            bit_cnt <= 5'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          rx_shft <= rx_next;
          bit_cnt <= cnt_next;
          // The first bit is already on MISO, so the first fall is skipped
          if (sclk_fall && (bit_cnt != 5'd0)) begin
            tx_shft <= {tx_shft[14:0], 1'b0};
          end
          if (ss_rise) begin
            state <= IDLE;
            if (cnt_next == 5'd16) begin
              chnl    <= sel_ch;
              resp    <= {4'h0, ch_arr[sel_ch]};
              cmd_rdy <= 1'b1;
            end else begin
              xfer_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_a2d_spi_serf.sv
// ============================================================================
// tb_a2d_spi_serf : randomized SPI transactions against two serf instances
// (8 and 4 channels) checked by a transaction-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_a2d_spi_serf;
  localparam int RST_CHNL = 0;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss_n  = 1'b1;
  logic        sclk  = 1'b0;
  logic        mosi  = 1'b0;
  logic [95:0] ch_data = '0;
  logic        cmd_rdy8, xfer_err8, cmd_rdy4, xfer_err4;
  logic [2:0]  chnl8, chnl4;

  a2d_spi_serf_if if8 ();
  a2d_spi_serf_if if4 ();
  assign if8.SS_n = ss_n;
  assign if8.SCLK = sclk;
  assign if8.MOSI = mosi;
  assign if4.SS_n = ss_n;
  assign if4.SCLK = sclk;
  assign if4.MOSI = mosi;

  a2d_spi_serf #(.NUM_CH(8), .RST_CHNL(RST_CHNL)) dut8 (
    .clk(clk), .rst_n(rst_n), .spi(if8.slave), .ch_data(ch_data),
    .cmd_rdy(cmd_rdy8), .chnl(chnl8), .xfer_err(xfer_err8));

  a2d_spi_serf #(.NUM_CH(4), .RST_CHNL(RST_CHNL)) dut4 (
    .clk(clk), .rst_n(rst_n), .spi(if4.slave), .ch_data(ch_data[47:0]),
    .cmd_rdy(cmd_rdy4), .chnl(chnl4), .xfer_err(xfer_err4));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rdy [2] = '{0, 0};
  int n_err [2] = '{0, 0};

  always @(negedge clk) begin
    if (cmd_rdy8)  n_rdy[0] <= n_rdy[0] + 1;
    if (cmd_rdy4)  n_rdy[1] <= n_rdy[1] + 1;
    if (xfer_err8) n_err[0] <= n_err[0] + 1;
    if (xfer_err4) n_err[1] <= n_err[1] + 1;
  end

  // Model state: what each serf will return next, and its last channel
  logic [15:0] m_resp [2];
  logic [2:0]  m_chnl [2];
  int          numch  [2] = '{8, 4};
  logic [15:0] rx8, rx4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_resp(input int k, input logic [2:0] ch);
    if (int'(ch) >= numch[k]) return 16'h0000;
    return {4'h0, ch_data[12*ch +: 12]};
  endfunction

  function automatic logic [15:0] mk_cmd(input int ch);
    logic [15:0] c;
    c = 16'($urandom);
    c[13:11] = 3'(ch);
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_resp[k] = 16'h0000;
      m_chnl[k] = 3'(RST_CHNL);
    end
  endtask

  task automatic start_xfer();
    @(negedge clk);
    ss_n = 1'b0;
    rx8  = '0;
    rx4  = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [15:0] cmd, input int n, input bit chg);
    for (int i = 0; i < n; i++) begin
      mosi = cmd[(15 - i) & 15];
      repeat (6) @(negedge clk);
      rx8  = {rx8[14:0], if8.MISO};
      rx4  = {rx4[14:0], if4.MISO};
      sclk = 1'b1;
      repeat (6) @(negedge clk);
      sclk = 1'b0;
      if (chg && i == 8) ch_data = {$urandom, $urandom, $urandom};
    end
  endtask

  // One complete transaction of n SCLKs, then check MISO bits, pulses and chnl
  task automatic xfer(input logic [15:0] cmd, input int n, input bit chg);
    int b_rdy [2];
    int b_err [2];
    logic [15:0] exp_rx;
    for (int k = 0; k < 2; k++) begin
      b_rdy[k] = n_rdy[k];
      b_err[k] = n_err[k];
    end
    start_xfer();
    shift_bits(cmd, n, chg);
    repeat (6) @(negedge clk);
    ss_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (n == 0)       exp_rx = 16'h0000;
      else if (n <= 16) exp_rx = m_resp[k] >> (16 - n);
      else              exp_rx = m_resp[k] << (n - 16);
      check($sformatf("miso%0d", k), (k == 0) ? rx8 : rx4, exp_rx);
      if (n == 16) begin
        m_chnl[k] = cmd[13:11];
        m_resp[k] = ref_resp(k, cmd[13:11]);
      end
      check($sformatf("rdy%0d", k), n_rdy[k] - b_rdy[k], (n == 16) ? 1 : 0);
      check($sformatf("err%0d", k), n_err[k] - b_err[k], (n == 16) ? 0 : 1);
      check($sformatf("chnl%0d", k), (k == 0) ? chnl8 : chnl4, m_chnl[k]);
    end
    check("miso_idle", {if8.MISO, if4.MISO}, 2'b00);
  endtask

  initial begin
    int b_rdy [2];
    int b_err [2];
    int ch, n;
    int odd_n [6] = '{0, 3, 9, 15, 17, 20};
    logic [11:0] sweep [4] = '{12'h111, 12'h222, 12'h333, 12'h444};
    int sweep_ch [4] = '{0, 1, 3, 4};

    ch_data = {$urandom, $urandom, $urandom};
    ch_data[12 +: 12] = 12'hABC;
    model_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_chnl8", chnl8, 3'(RST_CHNL));
    check("rst_chnl4", chnl4, 3'(RST_CHNL));
    check("rst_pulses", {cmd_rdy8, xfer_err8, cmd_rdy4, xfer_err4}, 4'b0000);
    check("rst_miso", {if8.MISO, if4.MISO}, 2'b00);

    // Channel 1 command, then read-back
    xfer(16'h0800, 16, 1'b0);
    check("t1_chnl", chnl8, 3'd1);
    xfer(mk_cmd($urandom_range(0, 7)), 16, 1'b0);
    check("t1_readback", rx8, 16'h0ABC);

    // Sweep the four board channels with distinct values
    for (int i = 0; i < 4; i++) ch_data[12*sweep_ch[i] +: 12] = sweep[i];
    for (int i = 0; i < 4; i++) xfer(mk_cmd(sweep_ch[i]), 16, 1'b0);
    xfer(mk_cmd(0), 16, 1'b0);
    check("t2_last", rx8, {4'h0, sweep[3]});

    // Early abort after 9 SCLKs, then a good transaction
    xfer(mk_cmd(2), 9, 1'b0);
    xfer(mk_cmd(3), 16, 1'b0);

    // Channel beyond the 4-channel instance
    xfer(mk_cmd(6), 16, 1'b0);
    check("t6_chnl4", chnl4, 3'd6);
    xfer(mk_cmd(1), 16, 1'b1);
    check("t6_zero4", rx4, 16'h0000);

    for (int it = 0; it < 30; it++) begin
      ch = $urandom_range(0, 7);
      n  = ($urandom_range(0, 4) == 0) ? odd_n[$urandom_range(0, 5)] : 16;
      xfer(mk_cmd(ch), n, 1'($urandom_range(0, 1)));
    end

    // Reset mid-transaction at bit 7, released with SS_n still low
    start_xfer();
    shift_bits(mk_cmd(5), 7, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    check("mid_rst_chnl8", chnl8, 3'(RST_CHNL));
    check("mid_rst_chnl4", chnl4, 3'(RST_CHNL));
    check("mid_rst_out", {cmd_rdy8, xfer_err8, cmd_rdy4, xfer_err4, if8.MISO, if4.MISO}, 6'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      b_rdy[k] = n_rdy[k];
      b_err[k] = n_err[k];
    end
    shift_bits(mk_cmd(5), 16, 1'b0);
    check("rel_low_miso", {if8.MISO, if4.MISO}, 2'b00);
    ss_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rel_low_rdy", (n_rdy[0] - b_rdy[0]) + (n_rdy[1] - b_rdy[1]), 0);
    check("rel_low_err", (n_err[0] - b_err[0]) + (n_err[1] - b_err[1]), 0);

    xfer(mk_cmd(7), 16, 1'b0);
    for (int it = 0; it < 10; it++) begin
      xfer(mk_cmd($urandom_range(0, 7)), 16, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
